// File: rtl/l2_master.sv
// SPI master, one byte per transaction, all four SPI modes.
//
// On a start request the block lowers chip select, generates 16 SCLK edges and shifts the
// byte out on MOSI, MSB first. At the same time it shifts MISO in and presents the received
// byte in parallel when the transaction completes. It is the initiator end of the link.
//
// Parameters:
//   MODE     SPI mode 0..3 (CPOL = MODE[1], CPHA = MODE[0])
//   CLK_DIV  clk cycles per SCLK half-period, 1..255
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   im_work_en    start request, honoured only while idle
//   om_work_end   one-cycle completion pulse
//   im_data_bus   byte to transmit, captured on the start cycle
//   om_data_bus   last received byte, held until the next completion
//   om_sclk_wire  serial clock, registered, idles at CPOL
//   om_mosi_wire  serial data out, registered, MSB first
//   im_miso_wire  serial data in
//   om_cs_n_wire  chip select, active low, registered
module l2_master #(
    parameter int unsigned MODE    = 0,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       im_work_en,
    output logic       om_work_end,
    input  logic [7:0] im_data_bus,
    output logic [7:0] om_data_bus,
    output logic       om_sclk_wire,
    output logic       om_mosi_wire,
    input  logic       im_miso_wire,
    output logic       om_cs_n_wire
);

    localparam logic [1:0] ModeBits = 2'(MODE);
    localparam logic       Cpol     = ModeBits[1];
    localparam logic       Cpha     = ModeBits[0];
    localparam logic [7:0] DivLast  = 8'(CLK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

    state_e     state_q, state_d;
    logic [7:0] div_q, div_d;
    logic [4:0] edge_q, edge_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic       sclk_q, sclk_d;
    logic       cs_n_q, cs_n_d;
    logic       mosi_q, mosi_d;
    logic       end_q, end_d;
    logic [7:0] data_q, data_d;

    logic div_tc;
    logic start;
    logic leading;
    logic do_sample;
    logic do_drive;

    assign div_tc = (div_q == DivLast);

    // A request seen in the completion cycle is not taken: the next transaction starts one
    // cycle later, which keeps cs_n high for two cycles between back-to-back transfers.
    assign start = (state_q == StIdle) && im_work_en && !end_q;

    // edge_q counts edges already produced, so the edge about to happen is odd (leading)
    // exactly when edge_q is even.
    assign leading   = ~edge_q[0];
    assign do_sample = leading ^ Cpha;
    // CPHA=0 already put bit 7 out at start, so only trailing edges 2..14 drive.
    assign do_drive  = Cpha ? leading : (!leading && (edge_q <= 5'd13));

    // State register (and the registered datapath/outputs).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            div_q   <= '0;
            edge_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            sclk_q  <= Cpol;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            end_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            edge_q  <= edge_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
            end_q   <= end_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StShift;
            StShift: if (div_tc && (edge_q == 5'd15)) state_d = StHold;
            StHold:  if (div_tc) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and shift registers.
    always_comb begin
        div_d  = div_q;
        edge_d = edge_q;
        tx_d   = tx_q;
        rx_d   = rx_q;
        sclk_d = sclk_q;
        cs_n_d = cs_n_q;
        mosi_d = mosi_q;
        end_d  = 1'b0;
        data_d = data_q;

        unique case (state_q)
            StIdle: begin
                cs_n_d = 1'b1;
                sclk_d = Cpol;
                mosi_d = 1'b0;
                div_d  = '0;
                edge_d = '0;
                if (start) begin
                    tx_d   = im_data_bus;
                    rx_d   = '0;
                    cs_n_d = 1'b0;
                    if (!Cpha) mosi_d = im_data_bus[7];
                end
            end
            StShift: begin
                if (div_tc) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + 5'd1;
                    if (do_sample) rx_d = {rx_q[6:0], im_miso_wire};
                    if (do_drive) begin
                        // CPHA=0 drives bits 6..0 (bit 7 went out at start), CPHA=1 bits 7..0.
                        mosi_d = Cpha ? tx_q[7] : tx_q[6];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            StHold: begin
                if (div_tc) begin
                    div_d  = '0;
                    cs_n_d = 1'b1;
                    mosi_d = 1'b0;
                    data_d = rx_q;
                    end_d  = 1'b1;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: begin
                cs_n_d = 1'b1;
                sclk_d = Cpol;
                mosi_d = 1'b0;
            end
        endcase
    end

    assign om_work_end  = end_q;
    assign om_data_bus  = data_q;
    assign om_sclk_wire = sclk_q;
    assign om_mosi_wire = mosi_q;
    assign om_cs_n_wire = cs_n_q;

endmodule
